// File: rtl/alu_result_stage.sv
// ALU result stage: a small writeback FIFO fed by the ALU, the architectural PSW flag register
// and a combinational branch-condition evaluator.
// Optional feature: define FLAG_STICKY_OV_EN to add a sticky overflow flag (so_clr / psw_so).
module alu_result_stage #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_out,
  input  logic          carryout,
  input  logic          overflow,
  input  logic          zero,
  input  logic          N,
  input  logic          flag_we,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_addr,
  output logic          wb_we,
  output logic [3:0]    psw,
`ifdef FLAG_STICKY_OV_EN
  input  logic          so_clr,
  output logic          psw_so,
`endif
  input  logic [3:0]    cond,
  output logic          cond_true
);

  // DEPTH is a power of two, so pointers wrap naturally at PW bits.
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic          we_q   [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    psw_q, psw_d;
  logic          push, pop;

  // Full refuses a push even if the head pops this cycle: keeps in_ready free of out_ready.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Entry storage; written only on an accepted push so idle inputs never leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
        we_q[i]   <= 1'b0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= alu_out;
      addr_q[wr_ptr_q] <= rd_addr;
      we_q[wr_ptr_q]   <= rd_we;
    end
  end

  // Head presentation; forced to zero when empty.
  always_comb begin
    wb_data = '0;
    wb_addr = '0;
    wb_we   = 1'b0;
    if (out_valid) begin
      wb_data = data_q[rd_ptr_q];
      wb_addr = addr_q[rd_ptr_q];
      wb_we   = we_q[rd_ptr_q];
    end
  end

  // PSW next-state: updated from the pushed result only, independent of writeback stalls.
  always_comb begin
    psw_d = psw_q;
    if (push && flag_we) psw_d = {N, zero, carryout, overflow};
  end

  // PSW register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psw_q <= 4'b0000;
    else        psw_q <= psw_d;
  end

  assign psw = psw_q;

`ifdef FLAG_STICKY_OV_EN
  logic psw_so_q, psw_so_d;

  // Sticky overflow next-state; a setting push beats a clear in the same cycle.
  always_comb begin
    psw_so_d = psw_so_q;
    if (so_clr) psw_so_d = 1'b0;
    if (push && flag_we && overflow) psw_so_d = 1'b1;
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psw_so_q <= 1'b0;
    else        psw_so_q <= psw_so_d;
  end

  assign psw_so = psw_so_q;
`endif

  // Branch condition evaluation on the current PSW.
  always_comb begin
    logic fn, fz, fc, fv;
    fn = psw_q[3];
    fz = psw_q[2];
    fc = psw_q[1];
    fv = psw_q[0];
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = fz;
      4'd1:    cond_true = ~fz;
      4'd2:    cond_true = fc;
      4'd3:    cond_true = ~fc;
      4'd4:    cond_true = fn;
      4'd5:    cond_true = ~fn;
      4'd6:    cond_true = fv;
      4'd7:    cond_true = ~fv;
      4'd8:    cond_true = fc & ~fz;
      4'd9:    cond_true = ~fc | fz;
      4'd10:   cond_true = (fn == fv);
      4'd11:   cond_true = (fn != fv);
      4'd12:   cond_true = ~fz & (fn == fv);
      4'd13:   cond_true = fz | (fn != fv);
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage: hand-written FIFO/reset sequences plus a
// table of PSW/condition-code vectors. Define FLAG_STICKY_OV_EN to also exercise psw_so.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_out;
  logic        carryout, overflow, zero, N;
  logic        flag_we;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        out_valid, out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic [3:0]  psw;
  logic [3:0]  cond;
  logic        cond_true;
`ifdef FLAG_STICKY_OV_EN
  logic        so_clr, psw_so;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.DW(32), .AW(5), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero),
    .N         (N),
    .flag_we   (flag_we),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_data   (wb_data),
    .wb_addr   (wb_addr),
    .wb_we     (wb_we),
    .psw       (psw),
`ifdef FLAG_STICKY_OV_EN
    .so_clr    (so_clr),
    .psw_so    (psw_so),
`endif
    .cond      (cond),
    .cond_true (cond_true)
  );

  typedef struct {
    logic [3:0] flags;  // {N,Z,C,V} to load into psw
    logic [3:0] cc;
    logic       exp;
  } cond_vec_t;

  cond_vec_t vecs [24];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Hold inputs for one rising edge, then return to idle 1ns after that edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a, input logic we,
                       input logic fw, input logic [3:0] f);
    in_valid = v;
    alu_out  = d;
    rd_addr  = a;
    rd_we    = we;
    flag_we  = fw;
    {N, zero, carryout, overflow} = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_out  = 32'hDEAD_BEEF;
    rd_addr  = 5'h1F;
    rd_we    = 1'b1;
    flag_we  = 1'b1;
    {N, zero, carryout, overflow} = 4'b1111;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {psw, cond, expected}
    vecs[0]  = '{4'b1000, 4'd11, 1'b1};
    vecs[1]  = '{4'b1000, 4'd10, 1'b0};
    vecs[2]  = '{4'b1000, 4'd4,  1'b1};
    vecs[3]  = '{4'b1000, 4'd5,  1'b0};
    vecs[4]  = '{4'b1000, 4'd12, 1'b0};
    vecs[5]  = '{4'b1000, 4'd13, 1'b1};
    vecs[6]  = '{4'b0100, 4'd0,  1'b1};
    vecs[7]  = '{4'b0100, 4'd1,  1'b0};
    vecs[8]  = '{4'b0100, 4'd8,  1'b0};
    vecs[9]  = '{4'b0100, 4'd9,  1'b1};
    vecs[10] = '{4'b0100, 4'd12, 1'b0};
    vecs[11] = '{4'b0010, 4'd2,  1'b1};
    vecs[12] = '{4'b0010, 4'd3,  1'b0};
    vecs[13] = '{4'b0010, 4'd8,  1'b1};
    vecs[14] = '{4'b0010, 4'd9,  1'b0};
    vecs[15] = '{4'b0001, 4'd6,  1'b1};
    vecs[16] = '{4'b0001, 4'd7,  1'b0};
    vecs[17] = '{4'b0001, 4'd10, 1'b0};
    vecs[18] = '{4'b0001, 4'd11, 1'b1};
    vecs[19] = '{4'b1001, 4'd12, 1'b1};
    vecs[20] = '{4'b1001, 4'd13, 1'b0};
    vecs[21] = '{4'b0000, 4'd12, 1'b1};
    vecs[22] = '{4'b0000, 4'd14, 1'b1};
    vecs[23] = '{4'b0000, 4'd15, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; cond = 4'd0;
    alu_out = '0; rd_addr = '0; rd_we = 1'b0; flag_we = 1'b0;
    {N, zero, carryout, overflow} = 4'b0000;
`ifdef FLAG_STICKY_OV_EN
    so_clr = 1'b0;
`endif
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_psw", psw, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_we", wb_we, 0);
    rst_n = 1'b1;
    idle_cycle();

    // Single push, one-cycle latency, then pop.
    out_ready = 1'b1;
    drive(1, 32'h0000_0005, 5'd3, 1, 0, 4'b0000);
    check("lat_out_valid", out_valid, 1);
    check("lat_wb_data", wb_data, 32'h5);
    check("lat_wb_addr", wb_addr, 3);
    check("lat_wb_we", wb_we, 1);
    idle_cycle();
    check("pop_empty_valid", out_valid, 0);
    check("pop_empty_data", wb_data, 0);

    // Backpressure: fill, refuse, full+pop still refuses, drain in order.
    out_ready = 1'b0;
    drive(1, 32'hAAAA_0001, 5'd1, 1, 0, 4'b0000);
    drive(1, 32'hBBBB_0002, 5'd2, 1, 0, 4'b0000);
    check("full_in_ready", in_ready, 0);
    check("full_head", wb_data, 32'hAAAA_0001);
    drive(1, 32'hCCCC_0003, 5'd4, 1, 0, 4'b0000);
    check("full_refuse_head", wb_data, 32'hAAAA_0001);
    check("full_refuse_ready", in_ready, 0);
    out_ready = 1'b1;
    drive(1, 32'hCCCC_0003, 5'd4, 1, 0, 4'b0000);
    check("drain_head2", wb_data, 32'hBBBB_0002);
    check("drain_addr2", wb_addr, 2);
    check("drain_ready", in_ready, 1);
    idle_cycle();
    check("drain_empty", out_valid, 0);

    // Simultaneous push+pop at count 1 keeps one entry, pointers wrap.
    out_ready = 1'b0;
    drive(1, 32'h1111_0000, 5'd5, 1, 0, 4'b0000);
    out_ready = 1'b1;
    drive(1, 32'h2222_0000, 5'd6, 0, 0, 4'b0000);
    check("pp_valid", out_valid, 1);
    check("pp_data", wb_data, 32'h2222_0000);
    check("pp_we", wb_we, 0);
    check("pp_ready", in_ready, 1);
    idle_cycle();
    check("pp_empty", out_valid, 0);

    // Compare op: flags-only result.
    out_ready = 1'b0;
    drive(1, 32'h0, 5'd7, 0, 1, 4'b0100);
    cond = 4'd0;
    #1;
    check("cmp_valid", out_valid, 1);
    check("cmp_wb_we", wb_we, 0);
    check("cmp_psw_z", psw[2], 1);
    check("cmp_eq", cond_true, 1);
    out_ready = 1'b1;
    // flag_we=0 push must leave psw alone.
    drive(1, 32'h9, 5'd8, 1, 0, 4'b1011);
    check("nofw_psw", psw, 4'b0100);
    idle_cycle();

    // Condition-code table.
    for (int i = 0; i < 24; i++) begin
      drive(1, 32'h0, 5'd0, 0, 1, vecs[i].flags);
      cond = vecs[i].cc;
      #1;
      check($sformatf("vec%0d_psw", i), psw, vecs[i].flags);
      check($sformatf("vec%0d_cond%0d", i, vecs[i].cc), cond_true, vecs[i].exp);
    end
    idle_cycle();

`ifdef FLAG_STICKY_OV_EN
    check("so_init", psw_so, 0);
    drive(1, 32'h0, 5'd0, 0, 1, 4'b0001);
    drive(1, 32'h0, 5'd0, 0, 1, 4'b0000);
    check("so_psw_v", psw[0], 0);
    check("so_held", psw_so, 1);
    so_clr = 1'b1;
    idle_cycle();
    check("so_cleared", psw_so, 0);
    drive(1, 32'h0, 5'd0, 0, 1, 4'b0001);
    check("so_set_wins", psw_so, 1);
    so_clr = 1'b0;
    idle_cycle();
`endif

    // Reset mid-stream with two entries queued.
    out_ready = 1'b0;
    drive(1, 32'h3333_0000, 5'd9, 1, 1, 4'b1010);
    drive(1, 32'h4444_0000, 5'd10, 1, 0, 4'b0000);
    check("mid_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_psw", psw, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_we", wb_we, 0);
    idle_cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle_cycle();
    check("post_rst_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
